ahb5_mem_subordinate: RTL and testbench

AHB5 responder (subordinate) forming the far end of the AHB5 random transaction generator's bus.
- Accepts pipelined single transfers into a small word-addressed register memory.
- Inserts wait states and returns two-cycle ERROR responses.
- Lets the generator, and any bridge-side checker, be exercised against a protocol-correct, timing-variable target.

---
 rtl/ahb5_sub_pkg.sv | 53 +++++
 rtl/ahb5_sub_lfsr.sv | 34 +++
 rtl/ahb5_mem_subordinate.sv | 235 +++++++++++++++++++++++
 tb/tb_ahb5_mem_subordinate.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb5_sub_pkg.sv
// ---------------------------------------------------------------------------
// ahb5_sub_pkg
//   Shared definitions for the AHB5 memory subordinate:
//     - HTRANS / HSIZE encodings
//     - subordinate FSM state enum
//     - LFSR tap mask and single-step helper (random-wait build)
//     - byte-lane strobe helper (size/addr -> 4-bit write strobe)
// ---------------------------------------------------------------------------
package ahb5_sub_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } sub_state_e;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAP_MASK)};
  endfunction

  // Byte lanes touched by a transfer of the given size at addr[1:0].
  // Illegal sizes select no lanes.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb5_sub_lfsr.sv
// ---------------------------------------------------------------------------
// ahb5_sub_lfsr
//   16-bit Fibonacci LFSR used to randomise subordinate wait states.
//   Advances one step on each cycle with en=1; resets to SEED.
// Ports:
//   HCLK    in   clock (rising edge)
//   HRESET  in   asynchronous active-high reset
//   en      in   advance enable
//   state   out  current 16-bit LFSR value
// ---------------------------------------------------------------------------
module ahb5_sub_lfsr
  import ahb5_sub_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign state = lfsr_reg;

endmodule

// File: rtl/ahb5_mem_subordinate.sv
// ---------------------------------------------------------------------------
// ahb5_mem_subordinate
//   AHB5 subordinate backed by a small word-addressed register memory.
//   Accepts pipelined single transfers, inserts wait states on OKAY
//   transfers and answers illegal accesses with a two-cycle ERROR.
//
//   Build option: define AHB5_SUB_RAND_WAIT_EN to take the per-transfer
//   wait count from an LFSR (0..7) instead of the fixed WAIT_STATES.
//
// Ports:
//   HCLK       in   bus clock
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   subordinate select
//   HADDR      in   byte address
//   HTRANS     in   transfer type
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size (0 byte, 1 half, 2 word)
//   HPROT      in   protection attributes (not checked)
//   HNONSEC    in   1 = non-secure access
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus ready, qualifies the address phase
//   HREADYOUT  out  this subordinate's ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  read data
// ---------------------------------------------------------------------------
module ahb5_mem_subordinate
  import ahb5_sub_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter int                    DEPTH        = 16,
  parameter int                    SECURE_WORDS = 4,
  parameter int                    WAIT_STATES  = 1,
  parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HNONSEC,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam int                    LANES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(4 * DEPTH);
  localparam logic [IDX_W:0]        SEC_LIM = (IDX_W + 1)'(SECURE_WORDS);

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      acc_idx;
  logic                  out_of_range;
  logic                  bad_size;
  logic                  misaligned;
  logic                  secure_viol;
  logic                  illegal;

  assign offset       = HADDR - BASE_ADDR;
  assign acc_idx      = offset[IDX_W+1:2];
  assign out_of_range = (HADDR < BASE_ADDR) || (offset >= SPAN);
  assign bad_size     = (HSIZE > HSIZE_WORD);
  assign misaligned   = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                        ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign secure_viol  = HNONSEC && ({1'b0, acc_idx} < SEC_LIM);
  assign illegal      = out_of_range || bad_size || misaligned || secure_viol;

  // -------------------------------------------------------------------------
  // Wait-count source
  // -------------------------------------------------------------------------
  logic [2:0] wait_load;
  logic       accept;
  logic       unused_ok;

`ifdef AHB5_SUB_RAND_WAIT_EN
  logic [15:0] lfsr_state;

  // Every accepted transfer (legal or not) steps the LFSR; the wait count
  // is taken from the value present at the accepting edge.
  ahb5_sub_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .en     (accept),
    .state  (lfsr_state)
  );

  assign wait_load = lfsr_state[2:0];
  assign unused_ok = ^{HPROT, lfsr_state[15:3]};
`else
  assign wait_load = 3'(WAIT_STATES);
  assign unused_ok = ^{HPROT, LFSR_SEED};
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  sub_state_e state_reg, state_next;
  logic [2:0] wcnt_reg,  wcnt_next;
  logic       pend_reg,  pend_next;   // legal transfer in its data phase
  logic       ready_int;
  logic       resp_int;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= IDLE;
      wcnt_reg  <= 3'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    pend_next  = pend_reg;
    ready_int  = 1'b1;
    resp_int   = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      IDLE: begin
        // A pending transfer completes in this cycle.
        pend_next = 1'b0;
      end
      WAIT: begin
        ready_int = 1'b0;
        wcnt_next = wcnt_reg - 3'd1;
        if (wcnt_reg <= 3'd1) begin
          state_next = IDLE;
        end
      end
      ERR1: begin
        ready_int  = 1'b0;
        resp_int   = 1'b1;
        state_next = ERR2;
      end
      ERR2: begin
        resp_int   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Address phases are only sampled while this subordinate is ready.
    accept = HSEL && HTRANS[1] && HREADY && ready_int;

    if (accept) begin
      if (illegal) begin
        state_next = ERR1;
        pend_next  = 1'b0;
      end else begin
        wcnt_next  = wait_load;
        pend_next  = 1'b1;
        state_next = (wait_load != 3'd0) ? WAIT : IDLE;
      end
    end
  end

  assign HREADYOUT = ready_int;
  assign HRESP     = resp_int;

  // -------------------------------------------------------------------------
  // Registered address phase
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_reg;
  logic             write_reg;
  logic [3:0]       strb_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_reg   <= '0;
      write_reg <= 1'b0;
      strb_reg  <= 4'b0000;
    end else if (accept) begin
      idx_reg   <= acc_idx;
      write_reg <= HWRITE;
      strb_reg  <= lane_strobe(HSIZE, HADDR[1:0]);
    end
  end

  // -------------------------------------------------------------------------
  // Memory
  // -------------------------------------------------------------------------
  logic                  data_done;
  logic                  commit_wr;
  logic                  rd_active;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Data phase finishes on the edge that ends an IDLE cycle with a pending
  // legal transfer; errored transfers never set pend_reg.
  assign data_done = (state_reg == IDLE) && pend_reg;
  assign commit_wr = data_done && write_reg;
  assign rd_active = data_done && !write_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_we[gi] = commit_wr && strb_reg[gi];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (lane_we[b]) begin
          mem[idx_reg][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Write commits at the end of its data phase, so a following read's data
  // phase already sees the new contents without a bypass path.
  assign HRDATA = rd_active ? mem[idx_reg] : '0;

endmodule

// File: tb/tb_ahb5_mem_subordinate.sv
module tb_ahb5_mem_subordinate;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DEPTH = 16;
  localparam int          SEC   = 4;
  localparam int          WS    = 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HNONSEC;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        hold;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
`ifdef AHB5_SUB_RAND_WAIT_EN
  logic [15:0] lfsr_m;
`endif

  assign HREADY = HREADYOUT & ~hold;

  always #5 HCLK = ~HCLK;

  ahb5_mem_subordinate #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (BASE),
    .DEPTH        (DEPTH),
    .SECURE_WORDS (SEC),
    .WAIT_STATES  (WS),
    .LFSR_SEED    (SEED)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HNONSEC   (HNONSEC),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
`ifdef AHB5_SUB_RAND_WAIT_EN
    lfsr_m = SEED;
`endif
  endtask

  // Wait cycles the next accepted transfer should see; steps the model LFSR.
  function automatic int next_wait();
`ifdef AHB5_SUB_RAND_WAIT_EN
    int w;
    w = int'(lfsr_m % 16'd8);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    return w;
`else
    return WS;
`endif
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] sz, input logic ns);
    int unsigned ua;
    ua = a;
    if (ua < BASE || ua > BASE + 4 * DEPTH - 1) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    if (ua % (32'd1 << sz) != 0) return 1'b1;
    if (ns && ((ua - BASE) / 4) < SEC) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int idx, off, n;
    idx = int'((a - BASE) / 4);
    off = int'(a % 4);
    n   = 1 << sz;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + n) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return mem_m[(a - BASE) / 4];
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HNONSEC = 1'b0;
  endtask

  // Count HREADYOUT-low cycles of a data phase (called at a negedge); bounded.
  task automatic count_waits(output int waits);
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge HCLK);
    end
  endtask

  // One non-pipelined transfer, entered and left at a negedge with an idle bus.
  task automatic xfer(input string tag, input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic ns, input logic [31:0] wd);
    bit err;
    int exp_w, waits;
    err   = is_illegal(a, sz, ns);
    exp_w = next_wait();
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HNONSEC = ns;
    @(posedge HCLK);
    @(negedge HCLK);
    bus_idle();
    HWDATA = wd;
    if (err) begin
      chk({tag, "_e1_rdy"}, {31'b0, HREADYOUT}, 32'd0);
      chk({tag, "_e1_resp"}, {31'b0, HRESP}, 32'd1);
      @(negedge HCLK);
      chk({tag, "_e2_rdy"}, {31'b0, HREADYOUT}, 32'd1);
      chk({tag, "_e2_resp"}, {31'b0, HRESP}, 32'd1);
      @(negedge HCLK);
      chk({tag, "_e3_resp"}, {31'b0, HRESP}, 32'd0);
      $display("xfer %s addr=%h wr=%0d size=%0d ns=%0d -> ERROR", tag, a, wr, sz, ns);
    end else begin
      count_waits(waits);
      chk({tag, "_waits"}, waits, exp_w);
      chk({tag, "_resp"}, {31'b0, HRESP}, 32'd0);
      if (wr) model_write(a, sz, wd);
      else chk({tag, "_rdata"}, HRDATA, model_read(a));
      @(negedge HCLK);
      $display("xfer %s addr=%h wr=%0d size=%0d ns=%0d waits=%0d data=%h", tag, a, wr, sz, ns,
               waits, wr ? wd : HRDATA);
    end
  endtask

  task automatic busy_cycle(input string tag, input logic [1:0] tr);
    HSEL = 1'b1; HADDR = BASE; HTRANS = tr;
    @(posedge HCLK);
    @(negedge HCLK);
    bus_idle();
    chk({tag, "_rdy"}, {31'b0, HREADYOUT}, 32'd1);
    chk({tag, "_resp"}, {31'b0, HRESP}, 32'd0);
    $display("xfer %s htrans=%0d -> OKAY", tag, tr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, wd;
    logic [2:0]  sz;
    logic        ns, wr;
    int          w1, w2, waits;

    hold = 1'b0; HPROT = 4'h3; HWDATA = 32'h0; HADDR = 32'h0;
    bus_idle();
    HRESET = 1'b1;
    model_reset();
    repeat (3) @(negedge HCLK);
    chk("rst_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_resp", {31'b0, HRESP}, 32'd0);
    chk("rst_rdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Reset in the middle of a wait-stated read
    xfer("w10", BASE + 32'h10, 1'b1, 3'd2, 1'b0, 32'h1234_5678);
    w1 = next_wait();
    HSEL = 1'b1; HADDR = BASE + 32'h10; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK);
    #2;
    bus_idle();
    HRESET = 1'b1;
    #1;
    chk("rstmid_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("rstmid_resp", {31'b0, HRESP}, 32'd0);
    chk("rstmid_rdata", HRDATA, 32'd0);
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    xfer("r10_after_rst", BASE + 32'h10, 1'b0, 3'd2, 1'b0, 32'h0);

    // Back-to-back write then read of the same word
    w1 = next_wait();
    HSEL = 1'b1; HADDR = BASE + 32'h20; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HNONSEC = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    HWDATA = 32'hDEAD_BEEF;
    HWRITE = 1'b0;
    count_waits(waits);
    chk("b2b_w_waits", waits, w1);
    chk("b2b_w_resp", {31'b0, HRESP}, 32'd0);
    model_write(BASE + 32'h20, 3'd2, 32'hDEAD_BEEF);
    w2 = next_wait();
    @(posedge HCLK);
    @(negedge HCLK);
    bus_idle();
    count_waits(waits);
    chk("b2b_r_waits", waits, w2);
    chk("b2b_r_rdata", HRDATA, model_read(BASE + 32'h20));
    $display("xfer b2b addr=%h write+read data=%h", BASE + 32'h20, HRDATA);
    @(negedge HCLK);

    // Byte write into lane 3
    xfer("w20_full", BASE + 32'h20, 1'b1, 3'd2, 1'b0, 32'h1122_3344);
    xfer("w23_byte", BASE + 32'h23, 1'b1, 3'd0, 1'b0, 32'hAA00_0000);
    xfer("r20_byte", BASE + 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
    chk("byte_merge_model", model_read(BASE + 32'h20), 32'hAA22_3344);

    // Errors: non-secure to secure word, misaligned half, out of range
    xfer("w04_sec", BASE + 32'h04, 1'b1, 3'd2, 1'b0, 32'hCAFE_0004);
    xfer("r04_nonsec", BASE + 32'h04, 1'b0, 3'd2, 1'b1, 32'h0);
    xfer("r04_check", BASE + 32'h04, 1'b0, 3'd2, 1'b0, 32'h0);
    xfer("w31_misal", BASE + 32'h31, 1'b1, 3'd1, 1'b0, 32'hFFFF_FFFF);
    xfer("w40_range", BASE + 32'h40, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF);
    xfer("r30_check", BASE + 32'h30, 1'b0, 3'd2, 1'b0, 32'h0);
    xfer("w3c_top", BASE + 32'h3C, 1'b1, 3'd2, 1'b0, 32'h0BAD_F00D);
    xfer("r3c_top", BASE + 32'h3C, 1'b0, 3'd2, 1'b0, 32'h0);

    // HREADY low: address phase must not be taken
    hold = 1'b1;
    HSEL = 1'b1; HADDR = BASE + 32'h14; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    HWDATA = 32'h5555_5555;
    repeat (2) begin
      @(posedge HCLK);
      @(negedge HCLK);
      chk("hold_rdy", {31'b0, HREADYOUT}, 32'd1);
    end
    bus_idle();
    hold = 1'b0;
    @(negedge HCLK);
    xfer("r14_hold", BASE + 32'h14, 1'b0, 3'd2, 1'b0, 32'h0);

    // Reads with BUSY/IDLE cycles between (wait counts tracked by model)
    for (int i = 0; i < 20; i++) begin
      a = BASE + 32'h10 + 4 * $urandom_range(0, DEPTH - SEC - 1);
      xfer($sformatf("lf%0d", i), a, 1'b0, 3'd2, 1'b0, 32'h0);
      if ($urandom_range(0, 1) == 1) busy_cycle($sformatf("lfb%0d", i), 2'b01);
      else busy_cycle($sformatf("lfi%0d", i), 2'b00);
    end

    // Random legal and illegal transfers
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'd4;
        1:       a = BASE + 32'd64 + 4 * $urandom_range(0, 3);
        default: a = BASE + $urandom_range(0, 63);
      endcase
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz < 3'd3) a = a & ~((32'd1 << sz) - 32'd1);
      ns = ($urandom_range(0, 3) == 0);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      xfer($sformatf("rnd%0d", i), a, wr, sz, ns, wd);
    end

    // Final sweep of memory contents
    for (int i = 0; i < DEPTH; i++) begin
      xfer($sformatf("sweep%0d", i), BASE + 4 * i, 1'b0, 3'd2, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
